// File: rtl/control_loop_pkg.sv
// control_loop_pkg: shared control-loop command codes, bridge register map, status bits and states
package control_loop_pkg;
  localparam logic [7:0] CMD_READ   = 8'h00;
  localparam logic [7:0] CMD_WRITE  = 8'h80;
  localparam logic [7:0] CMD_P      = 8'h01;
  localparam logic [7:0] CMD_I      = 8'h02;
  localparam logic [7:0] CMD_D      = 8'h03;
  localparam logic [7:0] CMD_SETPT  = 8'h04;
  localparam logic [7:0] CMD_CYCLES = 8'h05;
  localparam logic [2:0] ADDR_WORD_LO   = 3'd0;
  localparam logic [2:0] ADDR_WORD_HI   = 3'd1;
  localparam logic [2:0] ADDR_CMD       = 3'd2;
  localparam logic [2:0] ADDR_STATUS    = 3'd3;
  localparam logic [2:0] ADDR_RESULT_LO = 3'd4;
  localparam logic [2:0] ADDR_RESULT_HI = 3'd5;
  localparam int ST_BUSY    = 0;
  localparam int ST_DONE    = 1;
  localparam int ST_TIMEOUT = 2;
  localparam int ST_OVERRUN = 3;
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_RELEASE = 2'd2
  } state_t;
endpackage

// File: rtl/control_loop_cmd_timer.sv
// control_loop_cmd_timer: handshake timeout counter, cleared on load, expires on the last allowed cycle
module control_loop_cmd_timer #(
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int TIMEOUT_WID    = 16
) (
  input  logic clk,
  input  logic rst_L,
  input  logic load,
  input  logic en,
  output logic expire
);
  logic [TIMEOUT_WID-1:0] cnt;
  // count cycles spent waiting, restarting at each launch
  always_ff @(posedge clk or negedge rst_L)
    if (!rst_L) cnt <= '0;
    else if (load) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
  assign expire = en && (cnt == TIMEOUT_WID'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/control_loop_cmd_bridge.sv
// control_loop_cmd_bridge: CPU register bus to control-loop start/finish handshake; optional timeout under CONTROL_LOOP_CMD_TIMEOUT_EN
module control_loop_cmd_bridge
  import control_loop_pkg::*;
#(
  parameter int DATA_WID       = 64,
  parameter int CMD_WID        = 8,
  parameter int BUS_WID        = 32,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int TIMEOUT_WID    = 16
) (
  input  logic                clk,
  input  logic                rst_L,
  input  logic [2:0]          bus_addr,
  input  logic [BUS_WID-1:0]  bus_wdata,
  input  logic                bus_we,
  input  logic                bus_re,
  output logic [BUS_WID-1:0]  bus_rdata,
  output logic                bus_ack,
  output logic [CMD_WID-1:0]  cmd,
  output logic [DATA_WID-1:0] word_in,
  input  logic [DATA_WID-1:0] word_out,
  output logic                start_cmd,
  input  logic                finish_cmd
);
  state_t state, state_n;
  logic [BUS_WID-1:0] word_lo, word_hi, status, rd_val;
  logic [DATA_WID-1:0] result;
  logic done, tout, ovr, fin_q;
  logic rd, busy, reg_wr, launch, finish_rise, expire, capture, time_out;
  assign rd          = bus_re & ~bus_we;
  assign busy        = state != S_IDLE;
  assign reg_wr      = bus_we & (bus_addr <= ADDR_CMD);
  assign launch      = bus_we & (bus_addr == ADDR_CMD) & ~busy;
  assign finish_rise = finish_cmd & ~fin_q;
  assign start_cmd   = state == S_ISSUE;
  assign word_in     = {word_hi, word_lo};
`ifdef CONTROL_LOOP_CMD_TIMEOUT_EN
  control_loop_cmd_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TIMEOUT_WID   (TIMEOUT_WID)
  ) u_timer (
    .clk   (clk),
    .rst_L (rst_L),
    .load  (launch),
    .en    (start_cmd),
    .expire(expire)
  );
`else
  logic unused_cfg;
  assign unused_cfg = ^{TIMEOUT_CYCLES, TIMEOUT_WID};
  assign expire = 1'b0;
`endif
  // a finish level left over from before the launch must not complete it, so only a rising finish counts
  always_comb begin
    capture  = (state == S_ISSUE) && finish_rise;
    time_out = (state == S_ISSUE) && !finish_rise && expire;
    state_n  = (state == S_IDLE && launch)               ? S_ISSUE :
               (state == S_ISSUE && (capture || time_out)) ? S_RELEASE :
               (state == S_RELEASE && !finish_cmd)        ? S_IDLE : state;
  end
  // state register
  always_ff @(posedge clk or negedge rst_L)
    if (!rst_L) state <= S_IDLE;
    else state <= state_n;
  // command/data registers and sticky flags
  always_ff @(posedge clk or negedge rst_L)
    if (!rst_L) begin
      word_lo <= '0;
      word_hi <= '0;
      cmd     <= '0;
      result  <= '0;
      done    <= 1'b0;
      tout    <= 1'b0;
      ovr     <= 1'b0;
      fin_q   <= 1'b0;
    end else begin
      fin_q <= finish_cmd;
      if (reg_wr && !busy && bus_addr == ADDR_WORD_LO) word_lo <= bus_wdata;
      if (reg_wr && !busy && bus_addr == ADDR_WORD_HI) word_hi <= bus_wdata;
      if (launch) begin
        cmd  <= bus_wdata[CMD_WID-1:0];
        done <= 1'b0;
        tout <= 1'b0;
        ovr  <= 1'b0;
      end else begin
        if (reg_wr && busy) ovr <= 1'b1;
        if (capture) begin
          result <= word_out;
          done   <= 1'b1;
        end
        if (time_out) tout <= 1'b1;
      end
    end
  // status word assembly
  always_comb begin
    status = '0;
    status[ST_BUSY]    = busy;
    status[ST_DONE]    = done;
    status[ST_TIMEOUT] = tout;
    status[ST_OVERRUN] = ovr;
  end
  // read mux over the register map
  always_comb
    rd_val = bus_addr == ADDR_WORD_LO   ? word_lo :
             bus_addr == ADDR_WORD_HI   ? word_hi :
             bus_addr == ADDR_CMD       ? {{(BUS_WID-CMD_WID){1'b0}}, cmd} :
             bus_addr == ADDR_STATUS    ? status :
             bus_addr == ADDR_RESULT_LO ? result[BUS_WID-1:0] :
             bus_addr == ADDR_RESULT_HI ? result[DATA_WID-1:BUS_WID] : '0;
  // single-cycle ack with registered read data; a simultaneous write wins and reads back 0
  always_ff @(posedge clk or negedge rst_L)
    if (!rst_L) begin
      bus_ack   <= 1'b0;
      bus_rdata <= '0;
    end else begin
      bus_ack   <= bus_we | bus_re;
      bus_rdata <= rd ? rd_val : '0;
    end
endmodule

// File: tb/tb_control_loop_cmd_bridge.sv
// tb_control_loop_cmd_bridge: randomized and directed check of the command bridge against a behavioural model
module tb_control_loop_cmd_bridge;
  import control_loop_pkg::*;
  localparam int TO = 16;
`ifdef CONTROL_LOOP_CMD_TIMEOUT_EN
  localparam bit TO_ON = 1'b1;
`else
  localparam bit TO_ON = 1'b0;
`endif
  logic clk = 1'b0, rst_L = 1'b0;
  logic [2:0] bus_addr = '0;
  logic [31:0] bus_wdata = '0, bus_rdata;
  logic bus_we = 1'b0, bus_re = 1'b0, bus_ack;
  logic [7:0] cmd;
  logic [63:0] word_in, word_out = '0;
  logic start_cmd, finish_cmd = 1'b0;
  int tests = 0, fails = 0;
  bit resp_en = 1'b0, man_fin = 1'b0;
  int resp_delay = 3, resp_hold = 0;
  logic [63:0] resp_word = '0;
  int m_phase, m_cnt;
  logic [31:0] m_lo, m_hi, m_rdata;
  logic [7:0] m_cmd;
  logic [63:0] m_res;
  bit m_done, m_to, m_ov, m_fin_prev, m_ack;

  control_loop_cmd_bridge #(
    .DATA_WID(64), .CMD_WID(8), .BUS_WID(32), .TIMEOUT_CYCLES(TO), .TIMEOUT_WID(16)
  ) dut (
    .clk(clk), .rst_L(rst_L), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we),
    .bus_re(bus_re), .bus_rdata(bus_rdata), .bus_ack(bus_ack), .cmd(cmd), .word_in(word_in),
    .word_out(word_out), .start_cmd(start_cmd), .finish_cmd(finish_cmd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [2:0] a);
    case (a)
      3'd0: return m_lo;
      3'd1: return m_hi;
      3'd2: return {24'b0, m_cmd};
      3'd3: return {28'b0, m_ov, m_to, m_done, m_phase != 0};
      3'd4: return m_res[31:0];
      3'd5: return m_res[63:32];
      default: return 32'b0;
    endcase
  endfunction

  // behavioural model: one command in flight, flags sticky until the next accepted launch
  always @(posedge clk) begin : model_p
    int ph;
    ph = m_phase;
    if (!rst_L) begin
      m_phase = 0; m_cnt = 0; m_lo = 0; m_hi = 0; m_cmd = 0; m_res = 0;
      m_done = 0; m_to = 0; m_ov = 0; m_fin_prev = 0; m_ack = 0; m_rdata = 0;
    end else begin
      m_ack = bus_we || bus_re;
      m_rdata = (bus_re && !bus_we) ? m_read(bus_addr) : 32'b0;
      if (bus_we && bus_addr <= 3'd2) begin
        if (ph != 0) m_ov = 1;
        else if (bus_addr == 3'd0) m_lo = bus_wdata;
        else if (bus_addr == 3'd1) m_hi = bus_wdata;
        else begin
          m_cmd = bus_wdata[7:0]; m_done = 0; m_to = 0; m_ov = 0; m_phase = 1; m_cnt = 0;
        end
      end
      if (ph == 1) begin
        if (finish_cmd && !m_fin_prev) begin m_res = word_out; m_done = 1; m_phase = 2; end
        else if (TO_ON && m_cnt == TO - 1) begin m_to = 1; m_phase = 2; end
        else m_cnt++;
      end else if (ph == 2 && !finish_cmd) m_phase = 0;
      m_fin_prev = finish_cmd;
    end
    #1;
    chk("start_cmd", 64'(start_cmd), 64'(m_phase == 1));
    chk("cmd", 64'(cmd), 64'(m_cmd));
    chk("word_in", word_in, {m_hi, m_lo});
    chk("bus_ack", 64'(bus_ack), 64'(m_ack));
    chk("bus_rdata", 64'(bus_rdata), 64'(m_rdata));
  end

  // control-loop stand-in: automatic responder or manual finish level
  initial begin
    forever begin
      @(negedge clk);
      if (!resp_en) finish_cmd = man_fin;
      else if (start_cmd && !finish_cmd) begin
        repeat (resp_delay) @(negedge clk);
        finish_cmd = 1'b1;
        word_out = resp_word;
        for (int k = 0; k < 200 && start_cmd; k++) @(negedge clk);
        repeat (resp_hold) @(negedge clk);
        finish_cmd = 1'b0;
      end
    end
  end

  task automatic bus_op(input bit we, input bit re, input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    bus_addr = a; bus_wdata = d; bus_we = we; bus_re = re;
    @(negedge clk);
    bus_we = 1'b0; bus_re = 1'b0;
  endtask

  task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
    bus_op(1'b1, 1'b0, a, d);
  endtask

  task automatic rd_chk(input string name, input logic [2:0] a, input logic [31:0] exp);
    bus_op(1'b0, 1'b1, a, 32'b0);
    chk(name, 64'(bus_rdata), 64'(exp));
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    rst_L = 1'b1;
    chk("rst_start", 64'(start_cmd), 64'd0);
    chk("rst_ack", 64'(bus_ack), 64'd0);
    chk("rst_word_in", word_in, 64'd0);
    rd_chk("rst_status", ADDR_STATUS, 32'h0);
    // basic write command
    resp_en = 1; resp_delay = 3; resp_hold = 0; resp_word = 64'hAA;
    bus_wr(ADDR_WORD_LO, 32'h1234);
    bus_wr(ADDR_WORD_HI, 32'h0);
    bus_wr(ADDR_CMD, {24'b0, CMD_P | CMD_WRITE});
    chk("launch_start", 64'(start_cmd), 64'd1);
    chk("launch_cmd", 64'(cmd), 64'h81);
    chk("launch_word_in", word_in, 64'h1234);
    repeat (12) @(negedge clk);
    rd_chk("p_write_status", ADDR_STATUS, 32'h2);
    rd_chk("p_write_result", ADDR_RESULT_LO, 32'hAA);
    // setpoint read
    resp_word = 64'h0000_0000_0001_F000;
    bus_wr(ADDR_CMD, {24'b0, CMD_SETPT | CMD_READ});
    repeat (12) @(negedge clk);
    rd_chk("setpt_lo", ADDR_RESULT_LO, 32'h0001_F000);
    rd_chk("setpt_hi", ADDR_RESULT_HI, 32'h0);
    rd_chk("setpt_status", ADDR_STATUS, 32'h2);
    rd_chk("setpt_cmd", ADDR_CMD, 32'h04);
    rd_chk("unmapped_6", 3'd6, 32'h0);
    // overrun while issuing
    resp_delay = 10; resp_word = 64'h1111_2222_3333_4444;
    bus_wr(ADDR_CMD, {24'b0, CMD_P | CMD_WRITE});
    bus_wr(ADDR_WORD_LO, 32'hFFFF);
    chk("ovr_word_in", word_in, 64'h1234);
    rd_chk("ovr_status_busy", ADDR_STATUS, 32'h9);
    repeat (20) @(negedge clk);
    rd_chk("ovr_status_done", ADDR_STATUS, 32'hA);
    rd_chk("ovr_word_lo", ADDR_WORD_LO, 32'h1234);
    rd_chk("ovr_result_hi", ADDR_RESULT_HI, 32'h1111_2222);
    // finish held through release
    resp_delay = 2; resp_hold = 5; resp_word = 64'h5;
    bus_wr(ADDR_CMD, {24'b0, CMD_I});
    n = 0;
    while (start_cmd && n < 50) begin @(negedge clk); n++; end
    chk("rel_start_drop", 64'(start_cmd), 64'd0);
    bus_wr(ADDR_CMD, {24'b0, CMD_D | CMD_WRITE});
    rd_chk("rel_status_busy", ADDR_STATUS, 32'hB);
    repeat (6) @(negedge clk);
    rd_chk("rel_status_idle", ADDR_STATUS, 32'hA);
    rd_chk("rel_cmd_kept", ADDR_CMD, 32'h02);
    // loop never finishes
    resp_en = 0; man_fin = 0; resp_hold = 0;
    bus_wr(ADDR_CMD, {24'b0, CMD_CYCLES});
`ifdef CONTROL_LOOP_CMD_TIMEOUT_EN
    n = 0;
    while (start_cmd && n < 100) begin n++; @(negedge clk); end
    chk("to_start_cycles", 64'(n), 64'(TO));
    repeat (2) @(negedge clk);
    rd_chk("to_status", ADDR_STATUS, 32'h4);
    rd_chk("to_result", ADDR_RESULT_LO, 32'h5);
`else
    repeat (40) @(negedge clk);
    chk("noto_start_held", 64'(start_cmd), 64'd1);
    rd_chk("noto_status", ADDR_STATUS, 32'h1);
    man_fin = 1; repeat (3) @(negedge clk);
    man_fin = 0; repeat (3) @(negedge clk);
    rd_chk("noto_status_done", ADDR_STATUS, 32'h2);
`endif
    // stale finish at launch does not complete
    man_fin = 1; repeat (2) @(negedge clk);
    bus_wr(ADDR_CMD, {24'b0, CMD_P});
    repeat (4) @(negedge clk);
    chk("stale_start", 64'(start_cmd), 64'd1);
    rd_chk("stale_status", ADDR_STATUS, 32'h1);
    man_fin = 0; repeat (2) @(negedge clk);
    man_fin = 1; repeat (3) @(negedge clk);
    chk("stale_done_start", 64'(start_cmd), 64'd0);
    man_fin = 0; repeat (3) @(negedge clk);
    rd_chk("stale_status_done", ADDR_STATUS, 32'h2);
    // reset mid-issue
    bus_wr(ADDR_CMD, {24'b0, CMD_P | CMD_WRITE});
    repeat (2) @(negedge clk);
    rst_L = 0;
    #1;
    chk("arst_start", 64'(start_cmd), 64'd0);
    chk("arst_cmd", 64'(cmd), 64'd0);
    chk("arst_word_in", word_in, 64'd0);
    @(negedge clk);
    rst_L = 1;
    rd_chk("arst_status", ADDR_STATUS, 32'h0);
    resp_en = 1; resp_delay = 3; resp_hold = 1; resp_word = 64'hDEAD_BEEF_0000_0077;
    bus_wr(ADDR_WORD_LO, 32'h77);
    bus_wr(ADDR_CMD, {24'b0, CMD_P | CMD_WRITE});
    repeat (12) @(negedge clk);
    rd_chk("arst_relaunch_status", ADDR_STATUS, 32'h2);
    rd_chk("arst_relaunch_hi", ADDR_RESULT_HI, 32'hDEAD_BEEF);
    // randomized traffic checked every cycle by the model
    for (int i = 0; i < 400; i++) begin
      int op;
      resp_delay = $urandom_range(0, 5);
      resp_hold = $urandom_range(0, 3);
      resp_word = {$urandom, $urandom};
      op = $urandom_range(0, 9);
      if (op < 3) bus_wr(3'd2, $urandom);
      else if (op < 5) bus_wr(3'($urandom_range(0, 7)), $urandom);
      else if (op < 8) bus_op(1'b0, 1'b1, 3'($urandom_range(0, 7)), 32'b0);
      else if (op == 8) bus_op(1'b1, 1'b1, 3'($urandom_range(0, 7)), $urandom);
      else repeat ($urandom_range(1, 6)) @(negedge clk);
    end
    repeat (20) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
